// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (F) and the data stage (M).
// Sequences the mem_req/mem_ack handshake with a per-transaction ack timeout.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [79:0]       if_rdata,
    output logic              if_valid,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [79:0]       mem_rdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    output logic              f_stall_req,
    output logic              m_stall_req
);

    // state  | meaning
    // IDLE   | port free; grants on the edge ending this cycle (M before F)
    // D_BUSY | data access in flight on the memory port
    // I_BUSY | 10-byte fetch in flight on the memory port
    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                done_q, done_d;
    logic [79:0]         if_rdata_q, if_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                if_err_q, if_err_d;
    logic [63:0]         d_rdata_q, d_rdata_d;
    logic                d_valid_q, d_valid_d;
    logic                d_err_q, d_err_d;
    logic                finish;
    logic                fin_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            done_q     <= 1'b0;
            if_rdata_q <= '0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            done_q     <= done_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            if_err_q   <= if_err_d;
            d_rdata_q  <= d_rdata_d;
            d_valid_q  <= d_valid_d;
            d_err_q    <= d_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        done_d     = 1'b0;
        if_rdata_d = if_rdata_q;
        if_valid_d = 1'b0;
        if_err_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        d_valid_d  = 1'b0;
        d_err_d    = 1'b0;
        finish     = 1'b0;
        fin_err    = 1'b0;

        case (state_q)
            IDLE: begin
                // done_q marks the valid-pulse cycle, which must not grant
                if (!done_q) begin
                    if (d_req) begin
                        state_d = D_BUSY;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        cnt_d   = '0;
                    end else if (if_req && !if_flush) begin
                        state_d = I_BUSY;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        cnt_d   = '0;
                    end
                end
            end
            D_BUSY, I_BUSY: begin
                if (state_q == I_BUSY && if_flush) flush_d = 1'b1;
                if (mem_ack) begin
                    finish  = 1'b1;
                    fin_err = mem_err;
                    if (state_q == D_BUSY && !we_q) d_rdata_d = mem_rdata[63:0];
                    if (state_q == I_BUSY) if_rdata_d = mem_rdata;
                end else if (cnt_q == TO_LAST) begin
                    finish  = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    flush_d = 1'b0;
                    if (state_q == D_BUSY) begin
                        d_valid_d = 1'b1;
                        d_err_d   = fin_err;
                    end else if (!(flush_q || if_flush)) begin
                        if_valid_d = 1'b1;
                        if_err_d   = fin_err;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req     = (state_q != IDLE);
    assign mem_we      = (state_q == D_BUSY) && we_q;
    assign mem_len     = (state_q == I_BUSY);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_valid    = if_valid_q;
    assign if_err      = if_err_q;
    assign d_rdata     = d_rdata_q;
    assign d_valid     = d_valid_q;
    assign d_err       = d_err_q;
    assign f_stall_req = if_req & ~if_valid_q;
    assign m_stall_req = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-written corner sequences;
// completions are checked against a scoreboard queue filled as stimulus is driven.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 64;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0, if_flush = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [79:0]       if_rdata;
    logic              if_valid, if_err;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [63:0]       d_wdata = '0;
    logic [63:0]       d_rdata;
    logic              d_valid, d_err;
    logic              mem_req, mem_we, mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [79:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0, mem_err = 1'b0;
    logic              f_stall_req, m_stall_req;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
        .f_stall_req(f_stall_req), .m_stall_req(m_stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          ack_dly;   // cycles after first mem_req cycle; -1 = never ack
        bit          merr;
        logic [79:0] rdata;
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [79:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [63:0] model_d = '0;
    logic [79:0] model_f = '0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Build the expected completion from the vector and the bench's own rdata model.
    task automatic push_exp(input vec_t v);
        exp_t e;
        e.is_d = v.is_d;
        e.err  = (v.ack_dly < 0) ? 1'b1 : v.merr;
        if (v.is_d) begin
            if (v.ack_dly >= 0 && !v.we) model_d = v.rdata[63:0];
            e.rdata = {16'h0, model_d};
        end else begin
            if (v.ack_dly >= 0) model_f = v.rdata;
            e.rdata = model_f;
        end
        sb.push_back(e);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n;
        push_exp(v);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        n = 0;
        do begin
            cyc();
            n++;
        end while (!mem_req && n < 20);
        chk({tag, "_grant_lat"}, 80'(n), 80'd1);
        if (!mem_req) begin
            d_req = 1'b0; if_req = 1'b0;
            return;
        end
        chk({tag, "_mem_len"}, 80'(mem_len), 80'(!v.is_d));
        chk({tag, "_mem_we"}, 80'(mem_we), 80'(v.is_d && v.we));
        chk({tag, "_mem_addr"}, 80'(mem_addr), 80'(v.addr));
        if (v.is_d && v.we) chk({tag, "_mem_wdata"}, 80'(mem_wdata), 80'(v.wdata));
        chk({tag, "_stall"}, 80'({f_stall_req, m_stall_req}), 80'({!v.is_d, v.is_d}));
        if (v.ack_dly < 0) begin
            n = 1;
            while (n < 40) begin
                cyc();
                if (!mem_req) break;
                n++;
            end
            chk({tag, "_timeout_len"}, 80'(n), 80'(TIMEOUT));
        end else begin
            repeat (v.ack_dly) cyc();
            chk({tag, "_req_held"}, 80'(mem_req), 80'd1);
            mem_ack = 1'b1; mem_err = v.merr; mem_rdata = v.rdata;
            cyc();
            mem_ack = 1'b0; mem_err = 1'b0;
        end
        // valid cycle: requester still holds req, which must not re-grant
        chk({tag, "_req_drop"}, 80'(mem_req), 80'd0);
        cyc();
        d_req = 1'b0; if_req = 1'b0;
        chk({tag, "_no_regrant"}, 80'(mem_req), 80'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 64'h100, 64'h0, 2, 1'b0, 80'h30F2_0011_2233_4455_6677};
        vecs[1] = '{1'b1, 1'b0, 64'h200, 64'h0, 0, 1'b0, 80'hAAAA_1122_3344_5566_7788};
        vecs[2] = '{1'b1, 1'b1, 64'h208, 64'hDEADBEEF, 1, 1'b0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 64'h210, 64'h0, -1, 1'b0, 80'h0};
        vecs[4] = '{1'b1, 1'b0, 64'h218, 64'h0, TIMEOUT - 1, 1'b0, 80'h0000_0BAD_F00D_CAFE_0001};
        vecs[5] = '{1'b0, 1'b0, 64'h120, 64'h0, 3, 1'b1, 80'h1234_5678_9ABC_DEF0_1357};
        vecs[6] = '{1'b1, 1'b1, 64'h220, 64'h55AA, 0, 1'b1, 80'h0};
        vecs[7] = '{1'b0, 1'b0, 64'h130, 64'h0, -1, 1'b0, 80'h0};

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (if_valid || d_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 80'({if_valid, d_valid}), 80'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("valid_owner", 80'({if_valid, d_valid}), e.is_d ? 80'b01 : 80'b10);
                        if (e.is_d) begin
                            chk("d_err", 80'(d_err), 80'(e.err));
                            chk("d_rdata", 80'(d_rdata), 80'(e.rdata[63:0]));
                        end else begin
                            chk("if_err", 80'(if_err), 80'(e.err));
                            if (!e.err || e.rdata == model_f) chk("if_rdata", if_rdata, e.rdata);
                        end
                    end
                end
            end
        join_none

        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_mem_req", 80'(mem_req), 80'd0);
        chk("rst_valids", 80'({if_valid, d_valid, if_err, d_err}), 80'd0);
        chk("rst_d_rdata", 80'(d_rdata), 80'd0);
        chk("rst_if_rdata", if_rdata, 80'd0);
        chk("rst_stalls", 80'({f_stall_req, m_stall_req}), 80'd0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // simultaneous requests: M first, F after one idle cycle
        begin
            vec_t vd, vf;
            vd = '{1'b1, 1'b0, 64'h200, 64'h0, 0, 1'b0, 80'h0000_0102_0304_0506_0708};
            vf = '{1'b0, 1'b0, 64'h140, 64'h0, 0, 1'b0, 80'hC0DE_1111_2222_3333_4444};
            push_exp(vd);
            push_exp(vf);
            d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
            if_req = 1'b1; if_addr = 64'h140;
            cyc();
            chk("both_d_first", 80'({mem_req, mem_len, mem_addr[15:0]}), 80'({1'b1, 1'b0, 16'h200}));
            chk("both_fstall1", 80'(f_stall_req), 80'd1);
            mem_ack = 1'b1; mem_rdata = vd.rdata;
            cyc();
            mem_ack = 1'b0;
            chk("both_dvalid", 80'({d_valid, mem_req}), 80'b10);
            chk("both_fstall2", 80'(f_stall_req), 80'd1);
            d_req = 1'b0;
            cyc();
            chk("both_idle_gap", 80'(mem_req), 80'd0);
            chk("both_fstall3", 80'(f_stall_req), 80'd1);
            cyc();
            chk("both_f_grant", 80'({mem_req, mem_len, mem_addr[15:0]}), 80'({1'b1, 1'b1, 16'h140}));
            mem_ack = 1'b1; mem_rdata = vf.rdata;
            cyc();
            mem_ack = 1'b0;
            chk("both_fvalid", 80'({if_valid, f_stall_req}), 80'b10);
            if_req = 1'b0;
            cyc();
        end

        // flush: blocks F grant in IDLE, suppresses if_valid when in flight
        if_req = 1'b1; if_addr = 64'h300; if_flush = 1'b1;
        cyc();
        chk("flush_idle_block", 80'(mem_req), 80'd0);
        if_flush = 1'b0;
        cyc();
        chk("flush_then_grant", 80'(mem_req), 80'd1);
        if_flush = 1'b1;
        cyc();
        if_flush = 1'b0; if_req = 1'b0;
        chk("flush_mem_side_held", 80'(mem_req), 80'd1);
        cyc();
        mem_ack = 1'b1; mem_rdata = 80'h9999_8888_7777_6666_5555;
        cyc();
        mem_ack = 1'b0;
        chk("flush_no_valid", 80'({if_valid, mem_req}), 80'd0);
        cyc();
        begin
            vec_t vn;
            vn = '{1'b0, 1'b0, 64'h400, 64'h0, 1, 1'b0, 80'h4444_3333_2222_1111_0000};
            run_txn(vn, "post_flush");
        end

        // late ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = '1;
        cyc();
        mem_ack = 1'b0;
        cyc();
        chk("late_ack_req", 80'(mem_req), 80'd0);
        chk("late_ack_d_rdata", 80'(d_rdata), 80'(model_d));

        // reset while D_BUSY
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
        cyc();
        chk("rstmid_busy", 80'(mem_req), 80'd1);
        rst = 1'b1;
        cyc();
        chk("rstmid_mem_req", 80'(mem_req), 80'd0);
        chk("rstmid_outputs", 80'({d_valid, if_valid, d_err, if_err, mem_we, mem_len}), 80'd0);
        chk("rstmid_rdata", 80'({16'h0, d_rdata} | if_rdata), 80'd0);
        rst = 1'b0; d_req = 1'b0;
        model_d = '0; model_f = '0;
        cyc();
        begin
            vec_t vr;
            vr = '{1'b1, 1'b0, 64'h508, 64'h0, 1, 1'b0, 80'h0000_7654_3210_FEDC_BA98};
            run_txn(vr, "after_rst");
        end

        repeat (3) cyc();
        chk("sb_drained", 80'(sb.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
